fix_msg_scheduler: RTL and testbench

Session-level scheduler that sequences the FIX body-length calculator and the downstream message serializer. It arbitrates among logon, logout and heartbeat send requests, then drives the body-length block's start and message-type inputs. It also owns the outgoing MsgSeqNum (binary value plus its ASCII digit count) and the heartbeat interval timer. It sits between session control logic and the bodylength/serializer datapath.

---
 rtl/fix_msg_scheduler.sv | 246 ++++++++++++++++++++++++
 tb/tb_fix_msg_scheduler.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_msg_scheduler.sv
// -----------------------------------------------------------------------------
// fix_msg_scheduler
//
// Session-level scheduler for the outgoing FIX message path. It arbitrates
// among Logout, Logon and Heartbeat send requests, starts the body-length
// calculator, hands the captured length to the serializer and waits for the
// serializer to finish. It also owns the outgoing MsgSeqNum (binary value plus
// its decimal digit count) and the heartbeat interval timer.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   logon_req_i         request to send a Logon (latched, merged while pending)
//   logout_req_i        request to send a Logout
//   hb_tick_i           one-cycle time-base tick for the heartbeat timer
//   hb_interval_i       heartbeat interval in ticks, 0 disables heartbeats
//   len_valid_i         body-length calculator result valid
//   msg_length_bin_i    binary body length from the calculator
//   tx_done_i           serializer finished the current message
//   start_o             one-cycle start pulse to the body-length calculator
//   create_message_o    message type code of the granted message
//   l_v_msgSeqNum_o     decimal digit count of seq_num_o (1..10)
//   seq_num_o           MsgSeqNum of the message in flight
//   body_len_o          captured body length
//   tx_start_o          one-cycle start pulse to the serializer
//   busy_o              high whenever a message is in flight
//   msg_sent_o          one-cycle pulse when a message completes
//   err_timeout_o       one-cycle pulse when the length never arrived
//   session_active_o    set by a sent Logon, cleared by a sent Logout
// -----------------------------------------------------------------------------
module fix_msg_scheduler #(
    parameter int SEQ_WIDTH = 32,
    parameter int TIMEOUT   = 64,
    parameter int HB_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 logon_req_i,
    input  logic                 logout_req_i,
    input  logic                 hb_tick_i,
    input  logic [HB_WIDTH-1:0]  hb_interval_i,
    input  logic                 len_valid_i,
    input  logic [7:0]           msg_length_bin_i,
    input  logic                 tx_done_i,
    output logic                 start_o,
    output logic [3:0]           create_message_o,
    output logic [3:0]           l_v_msgSeqNum_o,
    output logic [SEQ_WIDTH-1:0] seq_num_o,
    output logic [7:0]           body_len_o,
    output logic                 tx_start_o,
    output logic                 busy_o,
    output logic                 msg_sent_o,
    output logic                 err_timeout_o,
    output logic                 session_active_o
);

    // Message type codes driven on create_message_o.
    localparam logic [3:0] MSG_LOGON     = 4'd1;
    localparam logic [3:0] MSG_LOGOUT    = 4'd2;
    localparam logic [3:0] MSG_HEARTBEAT = 4'd3;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int THR_W = SEQ_WIDTH + 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_LEN = 2'd1,
        WAIT_TX  = 2'd2
    } state_t;

    state_t               state;
    logic                 pend_logout;
    logic                 pend_logon;
    logic                 pend_hb;
    logic [CNT_W-1:0]     timeout_cnt;
    logic [THR_W-1:0]     threshold;
    logic [HB_WIDTH-1:0]  hb_count;

    // -------------------------------------------------------------------------
    // Sequence-number helpers
    // -------------------------------------------------------------------------
    logic [SEQ_WIDTH-1:0] seq_plus;
    logic [THR_W-1:0]     thr_times_ten;
    logic                 seq_at_max;
    logic                 seq_hits_thr;

    always_comb begin
        seq_plus      = seq_num_o + SEQ_WIDTH'(1);
        seq_at_max    = &seq_num_o;
        // The digit count grows exactly when the new value reaches the next
        // power of ten, so a single equality against a running threshold is
        // enough; no divider is needed.
        seq_hits_thr  = ({4'b0000, seq_plus} == threshold);
        // x10 as (x<<3) + (x<<1)
        thr_times_ten = (threshold << 3) + (threshold << 1);
    end

    // -------------------------------------------------------------------------
    // Heartbeat timer
    // -------------------------------------------------------------------------
    logic                hb_enabled;
    logic [HB_WIDTH:0]   hb_count_plus;
    logic                hb_terminal;
    logic                msg_done;
    logic                hb_fire;

    always_comb begin
        hb_enabled    = session_active_o && (hb_interval_i != '0);
        hb_count_plus = {1'b0, hb_count} + {{HB_WIDTH{1'b0}}, 1'b1};
        // >= rather than == so a shrinking interval cannot strand the timer
        // above its new terminal value.
        hb_terminal   = hb_enabled && hb_tick_i &&
                        (hb_count_plus >= {1'b0, hb_interval_i});
        msg_done      = (state == WAIT_TX) && tx_done_i;
        // A completing message reloads the timer, which overrides a terminal
        // tick arriving in the same cycle.
        hb_fire       = hb_terminal && !msg_done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_count <= '0;
        end else if (msg_done) begin
            hb_count <= '0;
        end else if (hb_enabled && hb_tick_i) begin
            if (hb_terminal) begin
                hb_count <= '0;
            end else begin
                hb_count <= hb_count_plus[HB_WIDTH-1:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Main FSM, pending flags, sequence number and session state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            pend_logout      <= 1'b0;
            pend_logon       <= 1'b0;
            pend_hb          <= 1'b0;
            timeout_cnt      <= '0;
            start_o          <= 1'b0;
            tx_start_o       <= 1'b0;
            msg_sent_o       <= 1'b0;
            err_timeout_o    <= 1'b0;
            busy_o           <= 1'b0;
            create_message_o <= 4'd0;
            body_len_o       <= 8'd0;
            seq_num_o        <= SEQ_WIDTH'(1);
            l_v_msgSeqNum_o  <= 4'd1;
            threshold        <= THR_W'(10);
            session_active_o <= 1'b0;
        end else begin
            // One-cycle pulses default low.
            start_o       <= 1'b0;
            tx_start_o    <= 1'b0;
            msg_sent_o    <= 1'b0;
            err_timeout_o <= 1'b0;

            case (state)
                IDLE: begin
                    // Fixed priority: Logout > Logon > Heartbeat.
                    if (pend_logout) begin
                        pend_logout      <= 1'b0;
                        create_message_o <= MSG_LOGOUT;
                    end else if (pend_logon) begin
                        pend_logon       <= 1'b0;
                        create_message_o <= MSG_LOGON;
                    end else if (pend_hb) begin
                        pend_hb          <= 1'b0;
                        create_message_o <= MSG_HEARTBEAT;
                    end
                    if (pend_logout || pend_logon || pend_hb) begin
                        start_o     <= 1'b1;
                        busy_o      <= 1'b1;
                        timeout_cnt <= '0;
                        state       <= WAIT_LEN;
                    end
                end

                WAIT_LEN: begin
                    if (len_valid_i) begin
                        body_len_o <= msg_length_bin_i;
                        tx_start_o <= 1'b1;
                        state      <= WAIT_TX;
                    end else if (timeout_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // The granted message is dropped; sequence number and
                        // heartbeat timer are left untouched.
                        err_timeout_o <= 1'b1;
                        busy_o        <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + CNT_W'(1);
                    end
                end

                WAIT_TX: begin
                    if (tx_done_i) begin
                        msg_sent_o <= 1'b1;
                        busy_o     <= 1'b0;
                        state      <= IDLE;

                        if (seq_at_max) begin
                            seq_num_o       <= SEQ_WIDTH'(1);
                            l_v_msgSeqNum_o <= 4'd1;
                            threshold       <= THR_W'(10);
                        end else begin
                            seq_num_o <= seq_plus;
                            if (seq_hits_thr) begin
                                l_v_msgSeqNum_o <= l_v_msgSeqNum_o + 4'd1;
                                threshold       <= thr_times_ten;
                            end
                        end

                        if (create_message_o == MSG_LOGON) begin
                            session_active_o <= 1'b1;
                        end else if (create_message_o == MSG_LOGOUT) begin
                            session_active_o <= 1'b0;
                            pend_hb          <= 1'b0;
                        end
                    end
                end

                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase

            // Requests are latched in every state. Placed after the grant
            // logic so a request coinciding with the grant of the same type
            // re-arms the flag as a new pending message.
            if (logout_req_i) begin
                pend_logout <= 1'b1;
            end
            if (logon_req_i) begin
                pend_logon <= 1'b1;
            end
            if (hb_fire) begin
                pend_hb <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fix_msg_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fix_msg_scheduler
//
// Self-checking bench for fix_msg_scheduler. A cycle-by-cycle vector table
// covers reset, single Logon, Logout-over-Logon priority, request merge and
// re-latch on grant, and session clear/set. Hand-written sequences cover the
// heartbeat timer, the tx_done/tick collision, the digit-count boundaries,
// the length timeout and reset in the middle of a message.
// -----------------------------------------------------------------------------
module tb_fix_msg_scheduler;

    localparam int L = 1;   // Logon code
    localparam int O = 2;   // Logout code
    localparam int H = 3;   // Heartbeat code
    localparam int NVEC = 34;

    logic        clk = 1'b0;
    logic        rst;
    logic        logon_req;
    logic        logout_req;
    logic        hb_tick;
    logic [7:0]  hb_interval;
    logic        len_valid;
    logic [7:0]  msg_len;
    logic        tx_done;
    logic        start;
    logic [3:0]  create_message;
    logic [3:0]  digits;
    logic [31:0] seq_num;
    logic [7:0]  body_len;
    logic        tx_start;
    logic        busy;
    logic        msg_sent;
    logic        err_timeout;
    logic        session_active;

    fix_msg_scheduler #(
        .SEQ_WIDTH(32),
        .TIMEOUT  (64),
        .HB_WIDTH (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .logon_req_i     (logon_req),
        .logout_req_i    (logout_req),
        .hb_tick_i       (hb_tick),
        .hb_interval_i   (hb_interval),
        .len_valid_i     (len_valid),
        .msg_length_bin_i(msg_len),
        .tx_done_i       (tx_done),
        .start_o         (start),
        .create_message_o(create_message),
        .l_v_msgSeqNum_o (digits),
        .seq_num_o       (seq_num),
        .body_len_o      (body_len),
        .tx_start_o      (tx_start),
        .busy_o          (busy),
        .msg_sent_o      (msg_sent),
        .err_timeout_o   (err_timeout),
        .session_active_o(session_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        logon;
        logic        logout;
        logic        len_valid;
        logic [7:0]  len;
        logic        tx_done;
        logic        e_start;
        logic        e_tx_start;
        logic        e_sent;
        logic        e_busy;
        logic        e_session;
        logic [3:0]  e_create;
        logic [31:0] e_seq;
        logic [7:0]  e_body;
    } vec_t;

    vec_t    vecs [NVEC];
    int      pass_cnt  = 0;
    int      total_cnt = 0;
    longint  exp_seq;

    function automatic vec_t mk(input int r, input int lo, input int lout,
                                input int lv, input int len, input int dn,
                                input int es, input int et, input int em,
                                input int eb, input int ess, input int ec,
                                input int eq, input int ebd);
        vec_t v;
        v.rst        = r[0];
        v.logon      = lo[0];
        v.logout     = lout[0];
        v.len_valid  = lv[0];
        v.len        = len[7:0];
        v.tx_done    = dn[0];
        v.e_start    = es[0];
        v.e_tx_start = et[0];
        v.e_sent     = em[0];
        v.e_busy     = eb[0];
        v.e_session  = ess[0];
        v.e_create   = ec[3:0];
        v.e_seq      = eq;
        v.e_body     = ebd[7:0];
        return v;
    endfunction

    function automatic int ndig(input longint val);
        longint x;
        int d;
        x = val;
        d = 1;
        while (x >= 10) begin
            x = x / 10;
            d++;
        end
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic lo, input logic lout);
        logon_req  = lo;
        logout_req = lout;
        step();
        logon_req  = 1'b0;
        logout_req = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (!start && n < 10) begin
            step();
            n++;
        end
        chk(name, 64'(start), 64'd1);
    endtask

    // Called while the DUT waits for the length; optionally ticks the
    // heartbeat time base in the same cycle as tx_done.
    task automatic serve(input string name, input logic [7:0] len,
                         input logic tick_on_done);
        len_valid = 1'b1;
        msg_len   = len;
        step();
        len_valid = 1'b0;
        chk({name, "_tx_start"}, 64'(tx_start), 64'd1);
        chk({name, "_body_len"}, 64'(body_len), 64'(len));
        step();
        tx_done = 1'b1;
        hb_tick = tick_on_done;
        step();
        tx_done = 1'b0;
        hb_tick = 1'b0;
        chk({name, "_msg_sent"}, 64'(msg_sent), 64'd1);
    endtask

    task automatic tick();
        hb_tick = 1'b1;
        step();
        hb_tick = 1'b0;
        step();
    endtask

    initial begin
        int     first_err;
        int     k;
        logic   saw;

        rst         = 1'b1;
        logon_req   = 1'b0;
        logout_req  = 1'b0;
        hb_tick     = 1'b0;
        hb_interval = 8'd0;
        len_valid   = 1'b0;
        msg_len     = 8'd0;
        tx_done     = 1'b0;

        //       rst lo lo lv len  dn  st tx sn bs ss  cr  seq  body
        vecs[0]  = mk(0, 1, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0,    0, 1, 0, 0, 1, 0, L, 1, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0,    0, 0, 0, 0, 1, 0, L, 1, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0,    0, 0, 0, 0, 1, 0, L, 1, 0);
        vecs[4]  = mk(0, 0, 0, 1, 'h45, 0, 0, 1, 0, 1, 0, L, 1, 'h45);
        vecs[5]  = mk(0, 0, 0, 0, 0,    0, 0, 0, 0, 1, 0, L, 1, 'h45);
        vecs[6]  = mk(0, 0, 0, 0, 0,    1, 0, 0, 1, 0, 1, L, 2, 'h45);
        vecs[7]  = mk(0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 1, L, 2, 'h45);
        vecs[8]  = mk(1, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[9]  = mk(0, 1, 1, 0, 0,    0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[10] = mk(0, 0, 0, 0, 0,    0, 1, 0, 0, 1, 0, O, 1, 0);
        vecs[11] = mk(0, 0, 0, 1, 'h10, 0, 0, 1, 0, 1, 0, O, 1, 'h10);
        vecs[12] = mk(0, 0, 0, 0, 0,    1, 0, 0, 1, 0, 0, O, 2, 'h10);
        vecs[13] = mk(0, 0, 0, 0, 0,    0, 1, 0, 0, 1, 0, L, 2, 'h10);
        vecs[14] = mk(0, 0, 0, 1, 'h22, 0, 0, 1, 0, 1, 0, L, 2, 'h22);
        vecs[15] = mk(0, 0, 0, 0, 0,    1, 0, 0, 1, 0, 1, L, 3, 'h22);
        vecs[16] = mk(0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 1, L, 3, 'h22);
        vecs[17] = mk(0, 1, 0, 0, 0,    0, 0, 0, 0, 0, 1, L, 3, 'h22);
        vecs[18] = mk(0, 1, 0, 0, 0,    0, 1, 0, 0, 1, 1, L, 3, 'h22);
        vecs[19] = mk(0, 0, 0, 1, 'h05, 0, 0, 1, 0, 1, 1, L, 3, 'h05);
        vecs[20] = mk(0, 0, 0, 0, 0,    1, 0, 0, 1, 0, 1, L, 4, 'h05);
        vecs[21] = mk(0, 0, 0, 0, 0,    0, 1, 0, 0, 1, 1, L, 4, 'h05);
        vecs[22] = mk(0, 0, 0, 1, 'h06, 0, 0, 1, 0, 1, 1, L, 4, 'h06);
        vecs[23] = mk(0, 0, 0, 0, 0,    1, 0, 0, 1, 0, 1, L, 5, 'h06);
        vecs[24] = mk(0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 1, L, 5, 'h06);
        vecs[25] = mk(0, 0, 1, 0, 0,    0, 0, 0, 0, 0, 1, L, 5, 'h06);
        vecs[26] = mk(0, 0, 0, 0, 0,    0, 1, 0, 0, 1, 1, O, 5, 'h06);
        vecs[27] = mk(0, 0, 0, 1, 'h0B, 0, 0, 1, 0, 1, 1, O, 5, 'h0B);
        vecs[28] = mk(0, 0, 0, 0, 0,    1, 0, 0, 1, 0, 0, O, 6, 'h0B);
        vecs[29] = mk(0, 1, 0, 0, 0,    0, 0, 0, 0, 0, 0, O, 6, 'h0B);
        vecs[30] = mk(0, 0, 0, 0, 0,    0, 1, 0, 0, 1, 0, L, 6, 'h0B);
        vecs[31] = mk(0, 0, 0, 1, 'h0C, 0, 0, 1, 0, 1, 0, L, 6, 'h0C);
        vecs[32] = mk(0, 0, 0, 0, 0,    1, 0, 0, 1, 0, 1, L, 7, 'h0C);
        vecs[33] = mk(0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 1, L, 7, 'h0C);

        // ---------------- reset state ----------------
        step();
        step();
        chk("reset_seq",     64'(seq_num),        64'd1);
        chk("reset_digits",  64'(digits),         64'd1);
        chk("reset_busy",    64'(busy),           64'd0);
        chk("reset_session", 64'(session_active), 64'd0);
        chk("reset_create",  64'(create_message), 64'd0);
        chk("reset_body",    64'(body_len),       64'd0);
        chk("reset_start",   64'(start),          64'd0);
        rst = 1'b0;

        // ---------------- vector table ----------------
        for (int i = 0; i < NVEC; i++) begin
            rst        = vecs[i].rst;
            logon_req  = vecs[i].logon;
            logout_req = vecs[i].logout;
            len_valid  = vecs[i].len_valid;
            msg_len    = vecs[i].len;
            tx_done    = vecs[i].tx_done;
            step();
            chk($sformatf("row%0d_start", i),    64'(start),          64'(vecs[i].e_start));
            chk($sformatf("row%0d_tx_start", i), 64'(tx_start),       64'(vecs[i].e_tx_start));
            chk($sformatf("row%0d_msg_sent", i), 64'(msg_sent),       64'(vecs[i].e_sent));
            chk($sformatf("row%0d_err", i),      64'(err_timeout),    64'd0);
            chk($sformatf("row%0d_busy", i),     64'(busy),           64'(vecs[i].e_busy));
            chk($sformatf("row%0d_session", i),  64'(session_active), 64'(vecs[i].e_session));
            chk($sformatf("row%0d_create", i),   64'(create_message), 64'(vecs[i].e_create));
            chk($sformatf("row%0d_seq", i),      64'(seq_num),        64'(vecs[i].e_seq));
            chk($sformatf("row%0d_digits", i),   64'(digits),         64'd1);
            chk($sformatf("row%0d_body", i),     64'(body_len),       64'(vecs[i].e_body));
        end
        rst        = 1'b0;
        logon_req  = 1'b0;
        logout_req = 1'b0;
        len_valid  = 1'b0;
        tx_done    = 1'b0;
        exp_seq    = 7;

        // ---------------- heartbeat timer, two rounds ----------------
        hb_interval = 8'd3;
        for (int r = 0; r < 2; r++) begin
            tick();
            tick();
            chk($sformatf("hb%0d_no_early_start", r), 64'(start), 64'd0);
            chk($sformatf("hb%0d_idle", r),           64'(busy),  64'd0);
            hb_tick = 1'b1;
            step();
            hb_tick = 1'b0;
            chk($sformatf("hb%0d_latency1", r), 64'(start), 64'd0);
            step();
            chk($sformatf("hb%0d_start", r),  64'(start),          64'd1);
            chk($sformatf("hb%0d_create", r), 64'(create_message), 64'(H));
            serve($sformatf("hb%0d", r), 8'h3A, 1'b0);
            exp_seq++;
            chk($sformatf("hb%0d_seq", r), 64'(seq_num), 64'(exp_seq));
        end

        // ---------------- tx_done and terminal tick together ----------------
        hb_interval = 8'd1;
        do_req(1'b1, 1'b0);
        wait_start("coll_start");
        serve("coll", 8'h40, 1'b1);
        exp_seq++;
        chk("coll_seq", 64'(seq_num), 64'(exp_seq));
        saw = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            if (start) saw = 1'b1;
        end
        chk("coll_no_hb", 64'(saw), 64'd0);
        hb_interval = 8'd0;

        // ---------------- digit-count boundaries ----------------
        while (exp_seq < 100) begin
            do_req(1'b1, 1'b0);
            wait_start($sformatf("seq%0d_start", exp_seq));
            serve($sformatf("seq%0d", exp_seq), 8'h30, 1'b0);
            exp_seq++;
            chk($sformatf("seq%0d_value", exp_seq),  64'(seq_num), 64'(exp_seq));
            chk($sformatf("seq%0d_digits", exp_seq), 64'(digits),  64'(ndig(exp_seq)));
        end

        // ---------------- length timeout with a queued heartbeat ----------------
        hb_interval = 8'd1;
        do_req(1'b1, 1'b0);
        wait_start("to_start");
        hb_tick = 1'b1;
        step();
        hb_tick   = 1'b0;
        k         = 1;
        first_err = 0;
        if (err_timeout) first_err = k;
        while (first_err == 0 && k < 80) begin
            step();
            k++;
            if (err_timeout) first_err = k;
        end
        chk("to_cycles",  64'(first_err), 64'd64);
        chk("to_busy",    64'(busy),      64'd0);
        chk("to_seq",     64'(seq_num),   64'(exp_seq));
        chk("to_session", 64'(session_active), 64'd1);
        step();
        chk("to_err_one_cycle", 64'(err_timeout),    64'd0);
        chk("to_hb_start",      64'(start),          64'd1);
        chk("to_hb_create",     64'(create_message), 64'(H));
        serve("to_hb", 8'h2B, 1'b0);
        exp_seq++;
        chk("to_hb_seq", 64'(seq_num), 64'(exp_seq));
        hb_interval = 8'd0;

        // ---------------- asynchronous reset in WAIT_TX ----------------
        do_req(1'b1, 1'b0);
        wait_start("rst_start");
        len_valid = 1'b1;
        msg_len   = 8'h55;
        step();
        len_valid = 1'b0;
        chk("rst_tx_start", 64'(tx_start), 64'd1);
        logout_req = 1'b1;
        step();
        logout_req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_now_busy",    64'(busy),           64'd0);
        chk("rst_now_seq",     64'(seq_num),        64'd1);
        chk("rst_now_digits",  64'(digits),         64'd1);
        chk("rst_now_session", 64'(session_active), 64'd0);
        chk("rst_now_create",  64'(create_message), 64'd0);
        chk("rst_now_body",    64'(body_len),       64'd0);
        chk("rst_now_pulses",  64'({start, tx_start, msg_sent, err_timeout}), 64'd0);
        step();
        rst = 1'b0;
        saw = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            if (start || busy) saw = 1'b1;
        end
        chk("rst_pending_lost", 64'(saw),     64'd0);
        chk("rst_after_seq",    64'(seq_num), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
